// File: rtl/rx_bd_fsm.sv
// Preamble/data boundary detector: finds the first break in an alternating preamble on hard symbols,
// confirms it over a window, then tracks payload length until end of packet.
module rx_bd_fsm #(
    parameter int unsigned WIN_W = 8,
    parameter int unsigned PRE_W = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_qpsk,
    input  logic [PRE_W-1:0] cfg_min_pre,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic [LEN_W-1:0] cfg_pkt_len,
    input  logic             sym_vld,
    input  logic             sym_i,
    input  logic             sym_q,
    input  logic             PD_flag,
    input  logic             disassert_BD,
    output logic             bd_init,
    output logic             bd_flag,
    output logic [1:0]       bd_sgn,
    output logic             bd_false,
    output logic             bd_done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEARCH  = 2'd1,
        S_CONFIRM = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    state_t           r_state,   w_nxt_state;
    logic [PRE_W-1:0] r_alt_cnt, w_nxt_alt_cnt;
    logic [WIN_W-1:0] r_win_cnt, w_nxt_win_cnt;
    logic [LEN_W-1:0] r_pkt_cnt, w_nxt_pkt_cnt;
    logic             r_prev_i,  w_nxt_prev_i;
    logic             r_prev_q,  w_nxt_prev_q;
    logic             r_prev_ok, w_nxt_prev_ok;
    logic             r_bd_init, w_nxt_bd_init;
    logic             r_bd_flag, w_nxt_bd_flag;
    logic [1:0]       r_bd_sgn,  w_nxt_bd_sgn;
    logic             r_bd_false, w_nxt_bd_false;
    logic             r_bd_done, w_nxt_bd_done;

    logic             w_brk;
    logic [WIN_W-1:0] w_win_eff;
    logic [PRE_W-1:0] w_alt_inc;
    logic [LEN_W-1:0] w_pkt_inc;

    // In QPSK a break needs both rails to repeat; one repeating rail still counts as alternation.
    assign w_brk     = (sym_i == r_prev_i) && (!cfg_qpsk || (sym_q == r_prev_q));
    assign w_win_eff = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
    assign w_alt_inc = (r_alt_cnt == '1) ? r_alt_cnt : r_alt_cnt + PRE_W'(1);
    assign w_pkt_inc = (r_pkt_cnt == '1) ? r_pkt_cnt : r_pkt_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_alt_cnt  <= '0;
            r_win_cnt  <= '0;
            r_pkt_cnt  <= '0;
            r_prev_i   <= 1'b0;
            r_prev_q   <= 1'b0;
            r_prev_ok  <= 1'b0;
            r_bd_init  <= 1'b0;
            r_bd_flag  <= 1'b0;
            r_bd_sgn   <= 2'b00;
            r_bd_false <= 1'b0;
            r_bd_done  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_alt_cnt  <= w_nxt_alt_cnt;
            r_win_cnt  <= w_nxt_win_cnt;
            r_pkt_cnt  <= w_nxt_pkt_cnt;
            r_prev_i   <= w_nxt_prev_i;
            r_prev_q   <= w_nxt_prev_q;
            r_prev_ok  <= w_nxt_prev_ok;
            r_bd_init  <= w_nxt_bd_init;
            r_bd_flag  <= w_nxt_bd_flag;
            r_bd_sgn   <= w_nxt_bd_sgn;
            r_bd_false <= w_nxt_bd_false;
            r_bd_done  <= w_nxt_bd_done;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_alt_cnt  = r_alt_cnt;
        w_nxt_win_cnt  = r_win_cnt;
        w_nxt_pkt_cnt  = r_pkt_cnt;
        w_nxt_prev_i   = r_prev_i;
        w_nxt_prev_q   = r_prev_q;
        w_nxt_prev_ok  = r_prev_ok;
        w_nxt_bd_init  = 1'b0;
        w_nxt_bd_flag  = r_bd_flag;
        w_nxt_bd_sgn   = r_bd_sgn;
        w_nxt_bd_false = 1'b0;
        w_nxt_bd_done  = 1'b0;

        if (!PD_flag || disassert_BD) begin
            // Both aborts clear everything; they differ only in the landing state.
            w_nxt_state   = PD_flag ? S_SEARCH : S_IDLE;
            w_nxt_alt_cnt = '0;
            w_nxt_win_cnt = '0;
            w_nxt_pkt_cnt = '0;
            w_nxt_prev_i  = 1'b0;
            w_nxt_prev_q  = 1'b0;
            w_nxt_prev_ok = 1'b0;
            w_nxt_bd_flag = 1'b0;
            w_nxt_bd_sgn  = 2'b00;
        end else begin
            if (sym_vld && (r_state != S_IDLE)) begin
                w_nxt_prev_i  = sym_i;
                w_nxt_prev_q  = sym_q;
                w_nxt_prev_ok = 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    w_nxt_state = S_SEARCH;
                end
                S_SEARCH: begin
                    if (sym_vld && r_prev_ok) begin
                        if (!w_brk) begin
                            w_nxt_alt_cnt = w_alt_inc;
                        end else if (r_alt_cnt >= cfg_min_pre) begin
                            w_nxt_state   = S_CONFIRM;
                            w_nxt_win_cnt = WIN_W'(1);
                            w_nxt_bd_sgn  = {sym_q & cfg_qpsk, sym_i};
                            w_nxt_bd_init = 1'b1;
                        end else begin
                            w_nxt_alt_cnt = '0;
                        end
                    end
                end
                S_CONFIRM: begin
                    // A break outranks a window completing on the same symbol.
                    if (sym_vld) begin
                        if (w_brk) begin
                            w_nxt_state    = S_SEARCH;
                            w_nxt_alt_cnt  = '0;
                            w_nxt_bd_false = 1'b1;
                        end else if (r_win_cnt >= w_win_eff) begin
                            w_nxt_state   = S_LOCKED;
                            w_nxt_bd_flag = 1'b1;
                            w_nxt_pkt_cnt = '0;
                        end else begin
                            w_nxt_win_cnt = r_win_cnt + WIN_W'(1);
                        end
                    end
                end
                S_LOCKED: begin
                    if (sym_vld) begin
                        if ((cfg_pkt_len != '0) && (w_pkt_inc >= cfg_pkt_len)) begin
                            w_nxt_state   = S_SEARCH;
                            w_nxt_bd_flag = 1'b0;
                            w_nxt_bd_done = 1'b1;
                            w_nxt_alt_cnt = '0;
                            w_nxt_prev_ok = 1'b0;
                        end else begin
                            w_nxt_pkt_cnt = w_pkt_inc;
                        end
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                end
            endcase
        end
    end

    assign bd_init  = r_bd_init;
    assign bd_flag  = r_bd_flag;
    assign bd_sgn   = r_bd_sgn;
    assign bd_false = r_bd_false;
    assign bd_done  = r_bd_done;
    assign state    = r_state;

endmodule

// File: tb/tb_rx_bd_fsm.sv
// Scoreboard bench for rx_bd_fsm: stimulus queues the expected output event and its cycle,
// a monitor pops and compares whenever the DUT changes state/flag or pulses.
module tb_rx_bd_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_qpsk;
    logic [7:0]  cfg_min_pre;
    logic [7:0]  cfg_window;
    logic [15:0] cfg_pkt_len;
    logic        sym_vld;
    logic        sym_i;
    logic        sym_q;
    logic        PD_flag;
    logic        disassert_BD;
    logic        bd_init;
    logic        bd_flag;
    logic [1:0]  bd_sgn;
    logic        bd_false;
    logic        bd_done;
    logic [1:0]  state;

    rx_bd_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_qpsk     (cfg_qpsk),
        .cfg_min_pre  (cfg_min_pre),
        .cfg_window   (cfg_window),
        .cfg_pkt_len  (cfg_pkt_len),
        .sym_vld      (sym_vld),
        .sym_i        (sym_i),
        .sym_q        (sym_q),
        .PD_flag      (PD_flag),
        .disassert_BD (disassert_BD),
        .bd_init      (bd_init),
        .bd_flag      (bd_flag),
        .bd_sgn       (bd_sgn),
        .bd_false     (bd_false),
        .bd_done      (bd_done),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  st;
        logic        flag;
        logic [1:0]  sgn;
        logic        init;
        logic        fls;
        logic        done;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [1:0]  mon_state = 2'd0;
    logic        mon_flag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any state/flag change or pulse is an event that must match the queue head.
    initial begin
        ev_t a;
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (state != mon_state || bd_flag != mon_flag || bd_init || bd_false || bd_done) begin
                a = '{cyc, state, bd_flag, bd_sgn, bd_init, bd_false, bd_done};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event cyc=%0d got st=%0d flag=%b sgn=%b init=%b false=%b done=%b, none required",
                             a.cyc, a.st, a.flag, a.sgn, a.init, a.fls, a.done);
                end else begin
                    e = exp_q.pop_front();
                    if (a == e) n_pass++;
                    else $display("FAIL event cyc=%0d got st=%0d flag=%b sgn=%b init=%b false=%b done=%b; required cyc=%0d st=%0d flag=%b sgn=%b init=%b false=%b done=%b",
                                  a.cyc, a.st, a.flag, a.sgn, a.init, a.fls, a.done,
                                  e.cyc, e.st, e.flag, e.sgn, e.init, e.fls, e.done);
                end
            end
            mon_state = state;
            mon_flag  = bd_flag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s got %b required %b", name, act, req);
    endtask

    task automatic drive(input logic v, input logic i, input logic q, input logic pd,
                         input logic dis, input logic r);
        @(negedge clk);
        sym_vld = v; sym_i = i; sym_q = q; PD_flag = pd; disassert_BD = dis; rst = r;
        last_cyc = cyc;
    endtask

    task automatic sym(input logic i, input logic q);
        drive(1'b1, i, q, PD_flag, 1'b0, 1'b0);
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, PD_flag, 1'b0, 1'b0);
    endtask

    task automatic pd(input logic v);
        drive(1'b0, 1'b0, 1'b0, v, 1'b0, 1'b0);
    endtask

    task automatic syms(input string s);
        for (int k = 0; k < s.len(); k++) sym(s[k] == 8'h31, 1'b0);
    endtask

    task automatic symsq(input string si, input string sq);
        for (int k = 0; k < si.len(); k++) sym(si[k] == 8'h31, sq[k] == 8'h31);
    endtask

    // Expected event for the symbol/control just driven, visible on the next clock.
    task automatic ex(input logic [1:0] st, input logic fl, input logic [1:0] sg,
                      input logic ini, input logic fa, input logic dn);
        exp_q.push_back('{last_cyc + 1, st, fl, sg, ini, fa, dn});
    endtask

    initial begin
        rst = 1'b1; PD_flag = 1'b0; disassert_BD = 1'b0;
        sym_vld = 1'b0; sym_i = 1'b0; sym_q = 1'b0;
        cfg_qpsk = 1'b0; cfg_min_pre = 8'd4; cfg_window = 8'd3; cfg_pkt_len = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", state, 2'd0);
        chk("reset_flag", {1'b0, bd_flag}, 2'b00);
        chk("reset_sgn", bd_sgn, 2'b00);
        chk("reset_init", {1'b0, bd_init}, 2'b00);
        chk("reset_false", {1'b0, bd_false}, 2'b00);
        chk("reset_done", {1'b0, bd_done}, 2'b00);
        gap(2);

        // BPSK min_pre=4 window=3: lock, repeats ignored in LOCKED, then abort
        pd(1'b1);               ex(2'd1, 0, 2'b00, 0, 0, 0);
        syms("0101010");
        sym(0, 0);              ex(2'd2, 0, 2'b00, 1, 0, 0);
        syms("10");
        sym(1, 0);              ex(2'd3, 1, 2'b00, 0, 0, 0);
        syms("11");
        drive(0, 0, 0, 1, 1, 0); ex(2'd1, 0, 2'b00, 0, 0, 0);
        pd(1'b0);               ex(2'd0, 0, 2'b00, 0, 0, 0);

        // min_pre=8: early break rejected silently, then a long preamble locks
        gap(1); cfg_min_pre = 8'd8;
        pd(1'b1);               ex(2'd1, 0, 2'b00, 0, 0, 0);
        syms("010101");
        sym(1, 0);
        syms("010101010");
        sym(0, 0);              ex(2'd2, 0, 2'b00, 1, 0, 0);
        syms("10");
        sym(1, 0);              ex(2'd3, 1, 2'b00, 0, 0, 0);
        pd(1'b0);               ex(2'd0, 0, 2'b00, 0, 0, 0);

        // window=4: false break, break on window completion, disassert with brk, PD low in CONFIRM
        gap(1); cfg_min_pre = 8'd4; cfg_window = 8'd4;
        pd(1'b1);               ex(2'd1, 0, 2'b00, 0, 0, 0);
        syms("10101");
        sym(1, 0);              ex(2'd2, 0, 2'b01, 1, 0, 0);
        sym(0, 0);
        sym(0, 0);              ex(2'd1, 0, 2'b01, 0, 1, 0);
        syms("1010101");
        sym(1, 0);              ex(2'd2, 0, 2'b01, 1, 0, 0);
        syms("010");
        sym(0, 0);              ex(2'd1, 0, 2'b01, 0, 1, 0);
        syms("1010101");
        sym(1, 0);              ex(2'd2, 0, 2'b01, 1, 0, 0);
        drive(1, 1, 0, 1, 1, 0); ex(2'd1, 0, 2'b00, 0, 0, 0);
        syms("10101");
        sym(1, 0);              ex(2'd2, 0, 2'b01, 1, 0, 0);
        pd(1'b0);               ex(2'd0, 0, 2'b00, 0, 0, 0);

        // QPSK: single-rail repeats are alternation; both rails repeating is the break
        gap(1); cfg_qpsk = 1'b1; cfg_window = 8'd3;
        pd(1'b1);               ex(2'd1, 0, 2'b00, 0, 0, 0);
        symsq("0101", "1010");
        sym(1, 1); sym(0, 0); sym(1, 1); sym(0, 0);
        sym(1, 0);
        sym(1, 0);              ex(2'd2, 0, 2'b01, 1, 0, 0);
        sym(0, 1); sym(1, 0);
        sym(0, 1);              ex(2'd3, 1, 2'b01, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 0); ex(2'd1, 0, 2'b00, 0, 0, 0);
        symsq("10101", "10101");
        sym(1, 1);              ex(2'd2, 0, 2'b11, 1, 0, 0);
        pd(1'b0);               ex(2'd0, 0, 2'b00, 0, 0, 0);

        // pkt_len=10 with 1-of-3 symbol strobes, then window=0 and reset mid-LOCKED
        gap(1); cfg_qpsk = 1'b0; cfg_window = 8'd3; cfg_pkt_len = 16'd10;
        pd(1'b1);               ex(2'd1, 0, 2'b00, 0, 0, 0);
        syms("01010");
        sym(0, 0);              ex(2'd2, 0, 2'b00, 1, 0, 0);
        syms("10");
        sym(1, 0);              ex(2'd3, 1, 2'b00, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            sym(1, 0);
            if (k == 10) ex(2'd1, 0, 2'b00, 0, 0, 1);
            gap(2);
        end
        pd(1'b0);               ex(2'd0, 0, 2'b00, 0, 0, 0);
        gap(1); cfg_window = 8'd0; cfg_pkt_len = 16'd0;
        pd(1'b1);               ex(2'd1, 0, 2'b00, 0, 0, 0);
        syms("10101");
        sym(1, 0);              ex(2'd2, 0, 2'b01, 1, 0, 0);
        sym(0, 0);              ex(2'd3, 1, 2'b01, 0, 0, 0);
        syms("11");
        drive(0, 0, 0, 1, 0, 1); ex(2'd0, 0, 2'b00, 0, 0, 0);
        gap(1);                 ex(2'd1, 0, 2'b00, 0, 0, 0);
        pd(1'b0);               ex(2'd0, 0, 2'b00, 0, 0, 0);
        gap(4);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL missing_event required cyc=%0d st=%0d flag=%b sgn=%b init=%b false=%b done=%b",
                     e.cyc, e.st, e.flag, e.sgn, e.init, e.fls, e.done);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
